// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the network-interface injection stage.
//   coord_w()  - bit width of one mesh coordinate for a given mesh dimension
//   noc_hdr_t  - route header fields {dst_x, dst_y, src_x, src_y}
//   hdr_pack() - packs a header into a flat word: dst_x, dst_y, src_x, src_y
//                from bit 0 upward, each field XW or YW bits wide, rest zero
//   state_t    - injection FSM states {IDLE, BODY, DROP}
package noc_pkg;

   // Header fields are carried at this fixed width and trimmed by hdr_pack.
   localparam int unsigned HDR_FLD_W = 16;
   localparam int unsigned HDR_MAX_W = 4 * HDR_FLD_W;

   typedef enum logic [1:0] {
      IDLE,
      BODY,
      DROP
   } state_t;

   typedef struct packed {
      logic [HDR_FLD_W-1:0] dst_x;
      logic [HDR_FLD_W-1:0] dst_y;
      logic [HDR_FLD_W-1:0] src_x;
      logic [HDR_FLD_W-1:0] src_y;
   } noc_hdr_t;

   function automatic int unsigned coord_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [HDR_MAX_W-1:0] hdr_pack(input noc_hdr_t    h,
                                                     input int unsigned xw,
                                                     input int unsigned yw);
      logic [HDR_MAX_W-1:0] xm;
      logic [HDR_MAX_W-1:0] ym;
      logic [HDR_MAX_W-1:0] v;
      xm = (HDR_MAX_W'(1) << xw) - HDR_MAX_W'(1);
      ym = (HDR_MAX_W'(1) << yw) - HDR_MAX_W'(1);
      v  = (HDR_MAX_W'(h.dst_x) & xm)
         | ((HDR_MAX_W'(h.dst_y) & ym) << xw)
         | ((HDR_MAX_W'(h.src_x) & xm) << (xw + yw))
         | ((HDR_MAX_W'(h.src_y) & ym) << (2 * xw + yw));
      return v;
   endfunction

endpackage

// File: rtl/noc_out_reg.sv
// noc_out_reg: single-entry registered valid/ready stage.
//   clk, rst_n                    - clock, async active-low reset
//   in_valid/in_ready             - upstream handshake
//   in_data/in_last/in_user       - upstream flit
//   out_valid/out_ready           - downstream handshake
//   out_data/out_last/out_user    - registered flit, stable while out_valid && !out_ready
module noc_out_reg #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_user,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_user
);

   // Free when empty or when the held flit leaves this cycle.
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_user  <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
            out_last <= in_last;
            out_user <= in_user;
         end
      end
   end

endmodule

// File: rtl/noc_ni_inject.sv
// noc_ni_inject: network-interface injection stage. Converts the flat destination id
// of each local packet to mesh X/Y, prepends one route-header flit and forwards the
// body through a registered output stage. Out-of-range destinations are dropped.
//   clk, rst_n                          - clock, async active-low reset
//   s_tvalid/s_tready/s_tdata/s_tlast   - local packet stream
//   s_tdest                             - flat destination id, used on first beat only
//   m_tvalid/m_tready/m_tdata/m_tlast   - mesh-side flit stream
//   m_tuser                             - 1 on the header flit
//   err_drop                            - one-cycle pulse after a dropped packet's tail
// Optional build macro NOC_NI_PKT_CNT_EN adds pkt_cnt (headers accepted on m_*) and
// drop_cnt (dropped packets), both 32-bit wrapping counters.
module noc_ni_inject
   import noc_pkg::*;
#(
   parameter int unsigned MSH_W   = 4,
   parameter int unsigned MSH_H   = 4,
   parameter int unsigned NODE_N  = MSH_W * MSH_H,
   parameter int unsigned NODE_ID = 0,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned DEST_W  = $clog2(NODE_N) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tlast,
   input  logic [DEST_W-1:0] s_tdest,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tlast,
   output logic              m_tuser,
   output logic              err_drop
`ifdef NOC_NI_PKT_CNT_EN
   ,
   output logic [31:0]       pkt_cnt,
   output logic [31:0]       drop_cnt
`endif
);

   localparam int unsigned XW    = coord_w(MSH_W);
   localparam int unsigned YW    = coord_w(MSH_H);
   localparam int unsigned SRC_X = NODE_ID % MSH_W;
   localparam int unsigned SRC_Y = NODE_ID / MSH_W;

   state_t state;

   logic              legal;
   logic [DEST_W-1:0] dst_x_full;
   logic [DEST_W-1:0] dst_y_full;
   noc_hdr_t          hdr;
   logic [DATA_W-1:0] hdr_flit;

   logic              or_in_valid;
   logic              or_in_ready;
   logic [DATA_W-1:0] or_in_data;
   logic              or_in_last;
   logic              or_in_user;

   assign legal      = s_tdest < DEST_W'(NODE_N);
   assign dst_x_full = s_tdest % DEST_W'(MSH_W);
   assign dst_y_full = s_tdest / DEST_W'(MSH_W);

   always_comb begin
      hdr       = '0;
      hdr.dst_x = HDR_FLD_W'(dst_x_full);
      hdr.dst_y = HDR_FLD_W'(dst_y_full);
      hdr.src_x = HDR_FLD_W'(SRC_X);
      hdr.src_y = HDR_FLD_W'(SRC_Y);
   end

   assign hdr_flit = DATA_W'(hdr_pack(hdr, XW, YW));

   // In IDLE the first beat stays on the input while its header is emitted; the
   // same beat is then consumed in BODY (or discarded in DROP).
   always_comb begin
      s_tready    = 1'b0;
      or_in_valid = 1'b0;
      or_in_data  = s_tdata;
      or_in_last  = s_tlast;
      or_in_user  = 1'b0;
      unique case (state)
         IDLE: begin
            or_in_valid = s_tvalid && legal;
            or_in_data  = hdr_flit;
            or_in_last  = 1'b0;
            or_in_user  = 1'b1;
         end
         BODY: begin
            s_tready    = or_in_ready;
            or_in_valid = s_tvalid;
         end
         DROP: begin
            s_tready = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         err_drop <= 1'b0;
      end else begin
         err_drop <= 1'b0;
         case (state)
            IDLE: begin
               if (s_tvalid && or_in_ready) begin
                  state <= legal ? BODY : DROP;
               end
            end
            BODY: begin
               if (s_tvalid && s_tready && s_tlast) begin
                  state <= IDLE;
               end
            end
            DROP: begin
               if (s_tvalid && s_tlast) begin
                  err_drop <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   noc_out_reg #(
      .DATA_W(DATA_W)
   ) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (or_in_valid),
      .in_ready (or_in_ready),
      .in_data  (or_in_data),
      .in_last  (or_in_last),
      .in_user  (or_in_user),
      .out_valid(m_tvalid),
      .out_ready(m_tready),
      .out_data (m_tdata),
      .out_last (m_tlast),
      .out_user (m_tuser)
   );

`ifdef NOC_NI_PKT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (m_tvalid && m_tready && m_tuser) begin
            pkt_cnt <= pkt_cnt + 32'd1;
         end
         if (state == DROP && s_tvalid && s_tlast) begin
            drop_cnt <= drop_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_noc_ni_inject.sv
// Bench for noc_ni_inject on a 4x4 mesh, NODE_ID=5 (src_x=1, src_y=1, XW=YW=2).
module tb_noc_ni_inject;

   localparam int unsigned MSH_W   = 4;
   localparam int unsigned MSH_H   = 4;
   localparam int unsigned NODE_N  = 16;
   localparam int unsigned NODE_ID = 5;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned DEST_W  = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_tvalid;
   logic              s_tready;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tlast;
   logic [DEST_W-1:0] s_tdest;
   logic              m_tvalid;
   logic              m_tready;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tlast;
   logic              m_tuser;
   logic              err_drop;
`ifdef NOC_NI_PKT_CNT_EN
   logic [31:0]       pkt_cnt;
   logic [31:0]       drop_cnt;
`endif

   noc_ni_inject #(
      .MSH_W  (MSH_W),
      .MSH_H  (MSH_H),
      .NODE_N (NODE_N),
      .NODE_ID(NODE_ID),
      .DATA_W (DATA_W),
      .DEST_W (DEST_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .s_tdata (s_tdata),
      .s_tlast (s_tlast),
      .s_tdest (s_tdest),
      .m_tvalid(m_tvalid),
      .m_tready(m_tready),
      .m_tdata (m_tdata),
      .m_tlast (m_tlast),
      .m_tuser (m_tuser),
      .err_drop(err_drop)
`ifdef NOC_NI_PKT_CNT_EN
      ,
      .pkt_cnt (pkt_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
      logic        u;
   } flit_t;

   typedef struct {
      int unsigned dest;
      int unsigned nb;
      logic [63:0] hdr;
      bit          drop;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   flit_t       exp_q[$];
   int          hs_cyc[$];
   int          drops_seen = 0;
   int          drops_exp = 0;
   int          cnt_pkts = 0;
   int          cnt_drops = 0;
   bit          hold_v = 0;
   flit_t       hold_f;
   bit          stop_rdy;
   vec_t        tbl[9];

   // Reference header: fields laid out dst_x, dst_y, src_x, src_y from bit 0, 2 bits each.
   function automatic logic [63:0] model_hdr(input int unsigned dest);
      int unsigned x, y, sx, sy;
      x  = dest % MSH_W;
      y  = dest / MSH_W;
      sx = NODE_ID % MSH_W;
      sy = NODE_ID / MSH_W;
      return 64'(x + y * 4 + sx * 16 + sy * 64);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Mesh-side monitor: scoreboard, hold stability, err_drop pulse count.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = 0;
      end else begin
         if (hold_v) begin
            checks++;
            if (!m_tvalid || {m_tdata, m_tlast, m_tuser} !== hold_f) begin
               errors++;
               $display("FAIL hold_stable got v=%b %h want %h", m_tvalid,
                        {m_tdata, m_tlast, m_tuser}, hold_f);
            end
         end
         hold_v = m_tvalid && !m_tready;
         hold_f = {m_tdata, m_tlast, m_tuser};
         if (m_tvalid && m_tready) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_flit got %h want none", {m_tdata, m_tlast, m_tuser});
            end else begin
               flit_t e;
               e = exp_q.pop_front();
               if ({m_tdata, m_tlast, m_tuser} !== e) begin
                  errors++;
                  $display("FAIL flit got %h/%b/%b want %h/%b/%b", m_tdata, m_tlast, m_tuser,
                           e.d, e.l, e.u);
               end
            end
         end
         if (err_drop) drops_seen++;
      end
   end

   task automatic send_pkt(input int unsigned dest, input int unsigned nb,
                           input logic [63:0] hdr, input bit gaps, output int unsigned waits);
      bit legal;
      legal = dest < NODE_N;
      waits = 0;
      if (legal) begin
         exp_q.push_back('{hdr, 1'b0, 1'b1});
         cnt_pkts++;
      end else begin
         drops_exp++;
         cnt_drops++;
      end
      for (int b = 0; b < int'(nb); b++) begin
         logic [63:0] d;
         int          n;
         d = {$urandom, $urandom};
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         s_tvalid = 1'b1;
         s_tdata  = d;
         s_tlast  = (b == int'(nb) - 1);
         s_tdest  = (b == 0) ? DEST_W'(dest) : DEST_W'($urandom);
         n = 0;
         do begin
            @(negedge clk);
            waits++;
            n++;
         end while (!s_tready && n < 200);
         if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout got s_tready=0 want 1");
         end
         @(posedge clk);
         #1;
         if (legal) exp_q.push_back('{d, s_tlast, 1'b0});
      end
      s_tvalid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int unsigned w;
      logic [63:0] d0, d1, d2;

      tbl[0] = '{14, 1, 64'h5E, 1'b0};
      tbl[1] = '{3,  4, 64'h53, 1'b0};
      tbl[2] = '{16, 3, 64'h0,  1'b1};
      tbl[3] = '{0,  2, 64'h50, 1'b0};
      tbl[4] = '{15, 2, 64'h5F, 1'b0};
      tbl[5] = '{31, 1, 64'h0,  1'b1};
      tbl[6] = '{5,  5, 64'h55, 1'b0};
      tbl[7] = '{12, 3, 64'h5C, 1'b0};
      tbl[8] = '{9,  1, 64'h59, 1'b0};

      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      s_tdest  = '0;
      m_tready = 1'b0;
      #12;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", m_tdata, 64'd0);
      chk("rst_m_tlast_tuser", 64'({m_tlast, m_tuser}), 64'd0);
      chk("rst_err_drop", 64'(err_drop), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      m_tready = 1'b1;
      @(posedge clk);
      #1;

      // Single-beat packet: header one cycle after IDLE sees it, body one after accept.
      exp_q.push_back('{64'h5E, 1'b0, 1'b1});
      exp_q.push_back('{64'hA5, 1'b1, 1'b0});
      cnt_pkts++;
      s_tvalid = 1'b1;
      s_tdata  = 64'hA5;
      s_tlast  = 1'b1;
      s_tdest  = 5'd14;
      @(negedge clk);
      chk("idle_s_tready", 64'(s_tready), 64'd0);
      chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      chk("hdr_latency", {m_tdata[61:0], m_tvalid, m_tuser}, {62'h5E, 1'b1, 1'b1});
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      @(negedge clk);
      chk("body_latency", {m_tdata[62:0], m_tlast}, {63'hA5, 1'b1});
      drain("single_drain");

      // Table-driven packets with continuous m_tready.
      for (int i = 0; i < 9; i++) begin
         send_pkt(tbl[i].dest, tbl[i].nb, tbl[i].hdr, 1'b0, w);
         chk($sformatf("ready_cycles_%0d", i), 64'(w), 64'(tbl[i].nb + 1));
         if (tbl[i].drop) begin
            @(negedge clk);
            chk($sformatf("drop_pulse_%0d", i), 64'(err_drop), 64'd1);
            @(negedge clk);
            chk($sformatf("drop_pulse_end_%0d", i), 64'(err_drop), 64'd0);
            @(posedge clk);
            #1;
         end else begin
            drain($sformatf("tbl_drain_%0d", i));
         end
      end

      // m_tready low for four cycles mid-packet: output must hold, nothing lost.
      fork
         send_pkt(3, 4, 64'h53, 1'b0, w);
         begin
            repeat (2) @(posedge clk);
            #2;
            m_tready = 1'b0;
            repeat (4) @(posedge clk);
            #2;
            m_tready = 1'b1;
         end
      join
      drain("hold_drain");

      // Back-to-back 2-beat packets: six flits on consecutive cycles.
      send_pkt(0, 2, 64'h50, 1'b0, w);
      send_pkt(15, 2, 64'h5F, 1'b0, w);
      drain("b2b_drain");
      chk("b2b_span", 64'(hs_cyc[hs_cyc.size() - 1] - hs_cyc[hs_cyc.size() - 6]), 64'd5);

      // Reset during beat 2 of a 4-beat packet.
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      exp_q.push_back('{64'h55, 1'b0, 1'b1});
      exp_q.push_back('{d0, 1'b0, 1'b0});
      s_tvalid = 1'b1;
      s_tdata  = d0;
      s_tlast  = 1'b0;
      s_tdest  = 5'd5;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      s_tdata = d1;
      @(posedge clk);
      #1;
      s_tdata = d2;
      rst_n   = 1'b0;
      #1;
      chk("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("async_rst_s_tready", 64'(s_tready), 64'd0);
      cnt_pkts  = 0;
      cnt_drops = 0;
      s_tvalid  = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_flush", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      send_pkt(5, 2, 64'h55, 1'b0, w);
      drain("post_rst_drain");

      // Randomized packets, gaps and back-pressure against the reference model.
      stop_rdy = 1'b0;
      fork
         begin
            for (int p = 0; p < 40; p++) begin
               int unsigned dest;
               dest = $urandom_range(0, 21);
               send_pkt(dest, $urandom_range(1, 5), model_hdr(dest), 1'b1, w);
            end
            stop_rdy = 1'b1;
         end
         begin
            while (!stop_rdy) begin
               @(posedge clk);
               #2;
               m_tready = ($urandom_range(0, 2) != 0);
            end
            m_tready = 1'b1;
         end
      join
      drain("rand_drain");
      repeat (3) @(posedge clk);
      #1;
      chk("drop_pulses", 64'(drops_seen), 64'(drops_exp));
`ifdef NOC_NI_PKT_CNT_EN
      chk("pkt_cnt", 64'(pkt_cnt), 64'(cnt_pkts));
      chk("drop_cnt", 64'(drop_cnt), 64'(cnt_drops));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
